// File: rtl/fir_wb_sequencer_if.sv
// ----------------------------------------------------------------------------
// fir_wb_sequencer_if : stream, Wishbone-master and status bundle for the sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface fir_wb_sequencer_if;
  logic        s_valid_i;
  logic [31:0] s_data_i;
  logic        s_ready_o;
  logic        m_valid_o;
  logic [31:0] m_data_o;
  logic        m_ready_i;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        busy_o;
  logic        timeout_o;
  logic [15:0] sample_cnt_o;

  modport master (
    input  s_valid_i, s_data_i, m_ready_i, wbm_dat_i, wbm_ack_i,
    output s_ready_o, m_valid_o, m_data_o,
    output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
    output busy_o, timeout_o, sample_cnt_o
  );

  modport slave (
    output s_valid_i, s_data_i, m_ready_i, wbm_dat_i, wbm_ack_i,
    input  s_ready_o, m_valid_o, m_data_o,
    input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
    input  busy_o, timeout_o, sample_cnt_o
  );
endinterface

`default_nettype wire

// File: rtl/fir_wb_sequencer.sv
// ----------------------------------------------------------------------------
// fir_wb_sequencer : pushes each sample through a Wishbone FIR core and streams out the result
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fir_wb_sequencer #(
  parameter logic [31:0] DATAIN_ADR  = 32'h0000_0000,
  parameter logic [31:0] START_ADR   = 32'h0000_0004,
  parameter logic [31:0] DONE_ADR    = 32'h0000_0008,
  parameter logic [31:0] DATAOUT_ADR = 32'h0000_000C,
  parameter logic [15:0] POLL_LIMIT  = 16'd255
) (
  input  wire logic            wb_clk_i,
  input  wire logic            wb_rst_i,
  fir_wb_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_DATA  = 3'd1,
    S_WR_START = 3'd2,
    S_WR_CLR   = 3'd3,
    S_POLL     = 3'd4,
    S_RD_OUT   = 3'd5,
    S_OUT      = 3'd6
  } state_t;

  state_t      r_state;
  logic [31:0] r_sample;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic [3:0]  r_sel;
  logic        r_we;
  logic        r_cyc;
  logic        r_stb;
  logic        r_m_valid;
  logic [31:0] r_m_data;
  logic        r_timeout;
  logic [15:0] r_sample_cnt;
  logic [15:0] r_poll_cnt;

  logic        w_ack;
  logic [16:0] w_poll_next;

  // An ack only counts while this master actually has a cycle open.
  assign w_ack       = r_cyc && r_stb && bus.wbm_ack_i;
  assign w_poll_next = {1'b0, r_poll_cnt} + 17'd1;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state      <= S_IDLE;
      r_sample     <= 32'h0;
      r_adr        <= 32'h0;
      r_dat        <= 32'h0;
      r_sel        <= 4'h0;
      r_we         <= 1'b0;
      r_cyc        <= 1'b0;
      r_stb        <= 1'b0;
      r_m_valid    <= 1'b0;
      r_m_data     <= 32'h0;
      r_timeout    <= 1'b0;
      r_sample_cnt <= 16'h0;
      r_poll_cnt   <= 16'h0;
    end else begin
      // Each bus state opens its cycle on the edge after entry (cyc low) and
      // closes it on the ack edge, leaving one idle cycle before the next one.
      unique case (r_state)
        S_IDLE: begin
          if (bus.s_valid_i) begin
            r_sample <= bus.s_data_i;
            r_state  <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (!r_cyc) begin
            {r_cyc, r_stb, r_we, r_sel} <= {1'b1, 1'b1, 1'b1, 4'hF};
            r_adr <= DATAIN_ADR;
            r_dat <= r_sample;
          end else if (w_ack) begin
            {r_cyc, r_stb} <= 2'b00;
            r_state        <= S_WR_START;
          end
        end
        S_WR_START: begin
          if (!r_cyc) begin
            {r_cyc, r_stb, r_we, r_sel} <= {1'b1, 1'b1, 1'b1, 4'hF};
            r_adr <= START_ADR;
            r_dat <= 32'h1;
          end else if (w_ack) begin
            {r_cyc, r_stb} <= 2'b00;
            r_state        <= S_WR_CLR;
          end
        end
        S_WR_CLR: begin
          if (!r_cyc) begin
            {r_cyc, r_stb, r_we, r_sel} <= {1'b1, 1'b1, 1'b1, 4'hF};
            r_adr <= START_ADR;
            r_dat <= 32'h0;
          end else if (w_ack) begin
            {r_cyc, r_stb} <= 2'b00;
            r_poll_cnt     <= 16'h0;
            r_state        <= S_POLL;
          end
        end
        S_POLL: begin
          if (!r_cyc) begin
            {r_cyc, r_stb, r_we, r_sel} <= {1'b1, 1'b1, 1'b0, 4'hF};
            r_adr <= DONE_ADR;
            r_dat <= 32'h0;
          end else if (w_ack) begin
            {r_cyc, r_stb} <= 2'b00;
            if (bus.wbm_dat_i[0]) begin
              r_state <= S_RD_OUT;
            end else if (w_poll_next >= {1'b0, POLL_LIMIT}) begin
              r_timeout <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_poll_cnt <= w_poll_next[15:0];
            end
          end
        end
        S_RD_OUT: begin
          if (!r_cyc) begin
            {r_cyc, r_stb, r_we, r_sel} <= {1'b1, 1'b1, 1'b0, 4'hF};
            r_adr <= DATAOUT_ADR;
            r_dat <= 32'h0;
          end else if (w_ack) begin
            {r_cyc, r_stb} <= 2'b00;
            r_m_data       <= bus.wbm_dat_i;
            r_m_valid      <= 1'b1;
            r_state        <= S_OUT;
          end
        end
        S_OUT: begin
          if (bus.m_ready_i) begin
            r_m_valid    <= 1'b0;
            r_sample_cnt <= r_sample_cnt + 16'd1;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          {r_cyc, r_stb} <= 2'b00;
          r_state        <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.s_ready_o    = (r_state == S_IDLE);
  assign bus.busy_o       = (r_state != S_IDLE);
  assign bus.m_valid_o    = r_m_valid;
  assign bus.m_data_o     = r_m_data;
  assign bus.wbm_adr_o    = r_adr;
  assign bus.wbm_dat_o    = r_dat;
  assign bus.wbm_sel_o    = r_sel;
  assign bus.wbm_we_o     = r_we;
  assign bus.wbm_cyc_o    = r_cyc;
  assign bus.wbm_stb_o    = r_stb;
  assign bus.timeout_o    = r_timeout;
  assign bus.sample_cnt_o = r_sample_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fir_wb_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fir_wb_sequencer : self-checking bench with a behavioural FIR Wishbone slave
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fir_wb_sequencer;

  localparam logic [31:0] A_DIN   = 32'h0;
  localparam logic [31:0] A_START = 32'h4;
  localparam logic [31:0] A_DONE  = 32'h8;
  localparam logic [31:0] A_DOUT  = 32'hC;
  localparam int          LIMIT   = 4;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } txn_t;

  typedef struct {
    logic [31:0] sample;
    int          done_at;
    logic [31:0] result;
    int          delay;
    int          lag;
    int          exp_polls;
    bit          exp_valid;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  fir_wb_sequencer_if bus ();

  fir_wb_sequencer #(.POLL_LIMIT(16'(LIMIT))) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_cnt = 16'h0;
  bit          exp_timeout = 1'b0;

  txn_t got_log[$];
  txn_t exp_log[$];

  int          cfg_done_at = 1;
  int          cfg_delay = 0;
  logic [31:0] cfg_result = 32'h0;
  int          sl_wait = 0;
  int          sl_polls = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // FIR core stand-in: registered ack after cfg_delay extra cycles; done appears on poll cfg_done_at.
  always @(posedge clk) begin
    if (rst) begin
      bus.wbm_ack_i <= 1'b0;
      bus.wbm_dat_i <= 32'h0;
      sl_wait       <= 0;
    end else if (bus.wbm_cyc_o && bus.wbm_stb_o && !bus.wbm_ack_i) begin
      if (sl_wait >= cfg_delay) begin
        sl_wait       <= 0;
        bus.wbm_ack_i <= 1'b1;
        got_log.push_back({bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_we_o ? bus.wbm_dat_o : 32'h0});
        if (bus.wbm_we_o && bus.wbm_adr_o == A_DIN) sl_polls <= 0;
        if (!bus.wbm_we_o && bus.wbm_adr_o == A_DONE) begin
          sl_polls      <= sl_polls + 1;
          bus.wbm_dat_i <= ($urandom() & 32'hFFFF_FFFE) | 32'(sl_polls + 1 == cfg_done_at);
        end else if (!bus.wbm_we_o && bus.wbm_adr_o == A_DOUT) begin
          bus.wbm_dat_i <= cfg_result;
        end else begin
          bus.wbm_dat_i <= 32'h0;
        end
      end else begin
        sl_wait <= sl_wait + 1;
      end
    end else begin
      bus.wbm_ack_i <= 1'b0;
    end
  end

  // Bus protocol observer, sampled mid-cycle.
  bit          mon_en = 1'b0;
  int          proto_viol = 0;
  logic        mon_stb_q = 1'b0;
  logic        mon_ack_q = 1'b0;
  logic [64:0] mon_hold_q = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.wbm_cyc_o !== bus.wbm_stb_o) proto_viol++;
      if (bus.wbm_stb_o && bus.wbm_sel_o !== 4'hF) proto_viol++;
      if (mon_stb_q && bus.wbm_stb_o &&
          {bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_dat_o} !== mon_hold_q) proto_viol++;
      if (mon_ack_q && bus.wbm_cyc_o) proto_viol++;
      if (mon_stb_q && !bus.wbm_stb_o && !mon_ack_q) proto_viol++;
    end
    mon_stb_q  = bus.wbm_stb_o;
    mon_ack_q  = bus.wbm_ack_i;
    mon_hold_q = {bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_dat_o};
  end

  task automatic build_expected(input logic [31:0] smp, input int polls, input bit valid);
    exp_log.delete();
    exp_log.push_back({1'b1, A_DIN, smp});
    exp_log.push_back({1'b1, A_START, 32'h1});
    exp_log.push_back({1'b1, A_START, 32'h0});
    for (int i = 0; i < polls; i++) exp_log.push_back({1'b0, A_DONE, 32'h0});
    if (valid) exp_log.push_back({1'b0, A_DOUT, 32'h0});
  endtask

  task automatic send_sample(input logic [31:0] smp, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.s_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, ".s_ready_wait"}, 64'(ok), 64'd1);
    bus.s_valid_i = 1'b1;
    bus.s_data_i  = smp;
    @(negedge clk);
    bus.s_valid_i = 1'b0;
    bus.s_data_i  = $urandom();
  endtask

  task automatic run_sample(input vec_t v, input string tag);
    bit          got_valid = 1'b0;
    bit          ok = 1'b0;
    bit          stable = 1'b1;
    logic [31:0] got_data = 32'h0;
    int          mism = 0;
    int          polls = 0;
    cfg_done_at = v.done_at;
    cfg_result  = v.result;
    cfg_delay   = v.delay;
    got_log.delete();
    send_sample(v.sample, tag);
    for (int i = 0; i < 400; i++) begin
      if (bus.m_valid_o) begin
        got_valid = 1'b1;
        ok = 1'b1;
        break;
      end
      if (bus.s_ready_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, ".finish_wait"}, 64'(ok), 64'd1);
    if (got_valid) begin
      got_data = bus.m_data_o;
      for (int i = 0; i < v.lag; i++) begin
        if (!bus.m_valid_o || bus.m_data_o !== got_data || bus.s_ready_o) stable = 1'b0;
        @(negedge clk);
      end
      check({tag, ".out_hold"}, 64'(stable), 64'd1);
      bus.m_ready_i = 1'b1;
      @(negedge clk);
      bus.m_ready_i = 1'b0;
      check({tag, ".valid_drop"}, 64'(bus.m_valid_o), 64'd0);
      check({tag, ".m_data"}, 64'(got_data), 64'(v.result));
    end
    if (v.exp_valid) exp_cnt = exp_cnt + 16'd1;
    else exp_timeout = 1'b1;
    build_expected(v.sample, v.exp_polls, v.exp_valid);
    if (got_log.size() != exp_log.size()) mism++;
    for (int i = 0; i < got_log.size() && i < exp_log.size(); i++)
      if (got_log[i] !== exp_log[i]) mism++;
    foreach (got_log[i]) if (!got_log[i].we && got_log[i].adr == A_DONE) polls++;
    check({tag, ".buslog_mism"}, 64'(mism), 64'd0);
    check({tag, ".done_reads"}, 64'(polls), 64'(v.exp_polls));
    check({tag, ".m_valid_seen"}, 64'(got_valid), 64'(v.exp_valid));
    check({tag, ".sample_cnt"}, 64'(bus.sample_cnt_o), 64'(exp_cnt));
    check({tag, ".timeout"}, 64'(bus.timeout_o), 64'(exp_timeout));
    check({tag, ".idle_after"}, 64'({bus.s_ready_o, bus.busy_o}), 64'b10);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".cyc_stb_we"}, 64'({bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o}), 64'd0);
    check({tag, ".adr_dat"}, {bus.wbm_adr_o, bus.wbm_dat_o}, 64'd0);
    check({tag, ".sel"}, 64'(bus.wbm_sel_o), 64'd0);
    check({tag, ".m_out"}, 64'({bus.m_valid_o, bus.m_data_o}), 64'd0);
    check({tag, ".status"}, 64'({bus.busy_o, bus.timeout_o, bus.sample_cnt_o}), 64'd0);
    check({tag, ".s_ready"}, 64'(bus.s_ready_o), 64'd1);
  endtask

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    bit   found;
    vecs[0] = '{32'h0000_1234, 1, 32'hABCD_0001, 0, 0,  1, 1'b1};
    vecs[1] = '{32'h5555_AAAA, 4, 32'h0BAD_F00D, 0, 1,  4, 1'b1};
    vecs[2] = '{32'h0000_00FF, 3, 32'h1357_9BDF, 3, 2,  3, 1'b1};
    vecs[3] = '{32'hCAFE_0001, 2, 32'h2468_ACE0, 1, 10, 2, 1'b1};
    vecs[4] = '{32'hDEAD_BEEF, 0, 32'hFFFF_FFFF, 0, 0,  4, 1'b0};
    vecs[5] = '{32'h0000_0042, 1, 32'h0000_0042, 2, 0,  1, 1'b1};

    rst = 1'b1;
    bus.s_valid_i = 1'b0;
    bus.s_data_i  = 32'h0;
    bus.m_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("reset");
    mon_en = 1'b1;

    for (int i = 0; i < 6; i++) run_sample(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 16; i++) begin
      v.sample    = $urandom();
      v.done_at   = int'($urandom_range(0, 5));
      v.result    = $urandom();
      v.delay     = int'($urandom_range(0, 3));
      v.lag       = int'($urandom_range(0, 3));
      v.exp_valid = (v.done_at >= 1 && v.done_at <= LIMIT);
      v.exp_polls = v.exp_valid ? v.done_at : LIMIT;
      run_sample(v, $sformatf("rnd%0d", i));
    end

    // Reset while a DONE poll is on the bus.
    cfg_done_at = 0;
    cfg_delay   = 2;
    got_log.delete();
    send_sample(32'h0000_7777, "rstpoll");
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.wbm_cyc_o && !bus.wbm_we_o && bus.wbm_adr_o == A_DONE) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rstpoll.reached_poll", 64'(found), 64'd1);
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rstpoll.cyc_stb_drop", 64'({bus.wbm_cyc_o, bus.wbm_stb_o}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("rstpoll");
    exp_cnt     = 16'h0;
    exp_timeout = 1'b0;
    mon_en      = 1'b1;
    v = '{32'h0000_0099, 2, 32'h600D_CAFE, 1, 1, 2, 1'b1};
    run_sample(v, "after_rst");

    repeat (3) @(negedge clk);
    check("bus_protocol_violations", 64'(proto_viol), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
